// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron front-end: frame constants,
// loader state encoding, vector packing and the frame-length helper.
package perceptron_pkg;

    localparam int              DATA_W_DEF    = 8;
    localparam int              N_SAMPLES_DEF = 3;
    localparam int              DIM_DEF       = 2;
    localparam logic [7:0]      HDR_BYTE_DEF  = 8'hA5;

    // Loader states, kept as plain constants so older blocks can compare against them.
    typedef logic [2:0] state_t;
    localparam state_t ST_HUNT    = 3'd0;
    localparam state_t ST_LOAD_EP = 3'd1;
    localparam state_t ST_LOAD_W  = 3'd2;
    localparam state_t ST_LOAD_S  = 3'd3;
    localparam state_t ST_STREAM  = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Element k of a weight or feature vector sits at bits [k*DATA_W +: DATA_W].
    typedef logic [DIM_DEF-1:0][DATA_W_DEF-1:0] weight_vec_t;
    typedef logic [DIM_DEF-1:0][DATA_W_DEF-1:0] feature_vec_t;

    // Bytes in one frame: header, epoch count, weights, then features plus label per sample.
    function automatic int unsigned frame_len(input int unsigned n_samples, input int unsigned dim);
        return 2 + dim + n_samples * (dim + 1);
    endfunction

endpackage

// File: rtl/perceptron_sample_buf.sv
// Sample register file: N_SAMPLES entries of DIM features plus a label.
// Byte-granular write port, whole-sample combinational read port.
module perceptron_sample_buf
    import perceptron_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DIM       = DIM_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    parameter int FLD_W     = $clog2(DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      i_wr_sample,
    input  logic [FLD_W-1:0]      i_wr_field,   // 0..DIM-1 feature, DIM label
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DIM*DATA_W-1:0] o_rd_x,
    output logic [DATA_W-1:0]     o_rd_y
);

    logic [DATA_W-1:0] r_mem [N_SAMPLES][DIM+1];

    // Store one incoming byte into the addressed sample field.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    // NOTE: the buffer is cleared on reset so an aborted frame cannot leak old samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SAMPLES; s++) begin
                for (int f = 0; f <= DIM; f++) begin
                    r_mem[s][f] <= '0;
                end
            end
        end else if (i_we) begin
            r_mem[i_wr_sample][i_wr_field] <= i_wr_data;
        end
    end

    // Present the whole selected sample, packed like the weight vector.
    always_comb begin
        o_rd_x = '0;
        o_rd_y = '0;
        if (int'(i_rd_idx) < N_SAMPLES) begin
            for (int k = 0; k < DIM; k++) begin
                o_rd_x[k*DATA_W +: DATA_W] = r_mem[i_rd_idx][k];
            end
            o_rd_y = r_mem[i_rd_idx][DIM];
        end
    end

endmodule

// File: rtl/perceptron_sample_loader.sv
// Byte-serial frame loader for the perceptron trainer: hunts for the header,
// captures epochs, weights and samples, then streams samples per epoch.
module perceptron_sample_loader
    import perceptron_pkg::*;
#(
    parameter int                N_SAMPLES = N_SAMPLES_DEF,
    parameter int                DIM       = DIM_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] HDR_BYTE  = HDR_BYTE_DEF,
    parameter int                IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIM*DATA_W-1:0] w_init,
    output logic                  w_load,
    output logic [DIM*DATA_W-1:0] s_x,
    output logic [DATA_W-1:0]     s_y,
    output logic [IDX_W-1:0]      s_idx,
    output logic [7:0]            s_epoch,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic                  s_last,
    output logic                  done,
    output logic                  hdr_err,
    output logic                  busy
);

    localparam int FLD_W = $clog2(DIM + 1);
    localparam int VEC_W = DIM * DATA_W;

    state_t            r_state;
    logic [7:0]        r_epochs;    // requested epoch count E
    logic [FLD_W-1:0]  r_cnt;       // weight byte in LOAD_W, field within sample in LOAD_S
    logic [IDX_W-1:0]  r_wsmp;      // sample being written in LOAD_S
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_epoch;
    logic [VEC_W-1:0]  r_w_shadow;  // weights being assembled; w_init only changes on w_load
    logic [VEC_W-1:0]  r_w_init;
    logic              r_w_load;
    logic              r_hdr_err;

    logic              w_take;
    logic              w_xfer;
    logic [VEC_W-1:0]  w_w_next;

    assign in_ready = (r_state == ST_HUNT)   || (r_state == ST_LOAD_EP) ||
                      (r_state == ST_LOAD_W) || (r_state == ST_LOAD_S);
    assign busy     = (r_state != ST_HUNT);
    assign s_valid  = (r_state == ST_STREAM);
    assign done     = (r_state == ST_DONE);
    assign s_last   = s_valid && (r_idx == IDX_W'(N_SAMPLES - 1)) && (r_epoch == r_epochs - 8'd1);
    assign w_init   = r_w_init;
    assign w_load   = r_w_load;
    assign hdr_err  = r_hdr_err;
    assign s_idx    = r_idx;
    assign s_epoch  = r_epoch;
    assign w_take   = in_valid && in_ready;
    assign w_xfer   = s_valid && s_ready;

    // Merge the byte arriving in LOAD_W into the weight vector under assembly.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_w_next = r_w_shadow;
        if (r_cnt < FLD_W'(DIM)) begin
            w_w_next[r_cnt*DATA_W +: DATA_W] = in_data;
        end
    end

    perceptron_sample_buf #(
        .N_SAMPLES (N_SAMPLES),
        .DIM       (DIM),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .FLD_W     (FLD_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_sample (r_wsmp),
        .i_wr_field  (r_cnt),
        .i_wr_data   (in_data),
        .i_we        (w_take && (r_state == ST_LOAD_S)),
        .i_rd_idx    (r_idx),
        .o_rd_x      (s_x),
        .o_rd_y      (s_y)
    );

    // Frame FSM with its byte, sample and epoch counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_epochs   <= '0;
            r_cnt      <= '0;
            r_wsmp     <= '0;
            r_idx      <= '0;
            r_epoch    <= '0;
            r_w_shadow <= '0;
            r_w_init   <= '0;
            r_w_load   <= 1'b0;
            r_hdr_err  <= 1'b0;
        end else begin
            r_w_load  <= 1'b0;
            r_hdr_err <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_take) begin
                        if (in_data == HDR_BYTE) r_state   <= ST_LOAD_EP;
                        else                     r_hdr_err <= 1'b1;
                    end
                end
                ST_LOAD_EP: begin
                    if (w_take) begin
                        r_epochs <= 8'(in_data);
                        r_cnt    <= '0;
                        r_state  <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (w_take) begin
                        r_w_shadow <= w_w_next;
                        if (r_cnt == FLD_W'(DIM - 1)) begin
                            r_w_init <= w_w_next;
                            r_w_load <= 1'b1;
                            r_cnt    <= '0;
                            r_wsmp   <= '0;
                            r_state  <= ST_LOAD_S;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_S: begin
                    if (w_take) begin
                        if (r_cnt == FLD_W'(DIM)) begin
                            r_cnt <= '0;
                            if (r_wsmp == IDX_W'(N_SAMPLES - 1)) begin
                                r_idx   <= '0;
                                r_epoch <= '0;
                                r_state <= (r_epochs == 8'd0) ? ST_DONE : ST_STREAM;
                            end else begin
                                r_wsmp <= r_wsmp + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (s_last) r_state <= ST_DONE;
                        if (r_idx == IDX_W'(N_SAMPLES - 1)) begin
                            r_idx   <= '0;
                            r_epoch <= r_epoch + 8'd1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE:  r_state <= ST_HUNT;
                default:  r_state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Self-checking bench: frames built as byte queues, expected transfers derived
// from the frame contents by plain epoch/sample loops.
module tb_perceptron_sample_loader;
    import perceptron_pkg::*;

    localparam int N    = 3;
    localparam int D    = 2;
    localparam int DW   = 8;
    localparam int IW   = 2;
    localparam int VW   = D * DW;
    localparam int FLEN = frame_len(N, D);

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          s_ready  = 1'b0;
    logic          in_ready;
    logic [VW-1:0] w_init;
    logic          w_load;
    logic [VW-1:0] s_x;
    logic [DW-1:0] s_y;
    logic [IW-1:0] s_idx;
    logic [7:0]    s_epoch;
    logic          s_valid;
    logic          s_last;
    logic          done;
    logic          hdr_err;
    logic          busy;

    perceptron_sample_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_init   (w_init),
        .w_load   (w_load),
        .s_x      (s_x),
        .s_y      (s_y),
        .s_idx    (s_idx),
        .s_epoch  (s_epoch),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .done     (done),
        .hdr_err  (hdr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] x;
        logic [DW-1:0] y;
        logic [IW-1:0] idx;
        logic [7:0]    ep;
        logic          last;
    } xfer_t;

    logic [7:0] frame_q[$];
    xfer_t      exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_w_load",   w_load,   0);
        check("rst_s_valid",  s_valid,  0);
        check("rst_s_last",   s_last,   0);
        check("rst_done",     done,     0);
        check("rst_hdr_err",  hdr_err,  0);
        check("rst_busy",     busy,     0);
        check("rst_w_init",   w_init,   0);
        check("rst_s_x",      s_x,      0);
        check("rst_s_y",      s_y,      0);
        check("rst_s_idx",    s_idx,    0);
        check("rst_s_epoch",  s_epoch,  0);
    endtask

    task automatic random_frame(input logic [7:0] e);
        frame_q.delete();
        frame_q.push_back(HDR_BYTE_DEF);
        frame_q.push_back(e);
        for (int i = 0; i < FLEN - 2; i++) frame_q.push_back(8'($urandom));
    endtask

    // Drive frame_q into the DUT and check the whole transaction against the model.
    // rmode: 0 = s_ready/in_valid always high, 1 = s_ready toggles, 2 = random both.
    task automatic run_frame(input int rmode, input bit junk);
        int            sent = 0;
        int            cyc = 0;
        int            wl_pulses = 0;
        int            he_pulses = 0;
        bit            fin = 0;
        bit            took, xfer, xfer_last;
        bit            tgl = 1;
        logic [7:0]    e;
        logic [VW-1:0] w_exp;
        xfer_t         t;

        e = frame_q[1];
        for (int k = 0; k < D; k++) w_exp[k*DW +: DW] = frame_q[2+k];
        exp_q.delete();
        for (int ep = 0; ep < int'(e); ep++) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < D; k++) t.x[k*DW +: DW] = frame_q[2+D+i*(D+1)+k];
                t.y    = frame_q[2+D+i*(D+1)+D];
                t.idx  = IW'(i);
                t.ep   = 8'(ep);
                t.last = (ep == int'(e) - 1) && (i == N - 1);
                exp_q.push_back(t);
            end
        end

        while (cyc < 5000) begin
            if (s_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", s_valid, 0);
                end else begin
                    check("s_x",     s_x,     exp_q[0].x);
                    check("s_y",     s_y,     exp_q[0].y);
                    check("s_idx",   s_idx,   exp_q[0].idx);
                    check("s_epoch", s_epoch, exp_q[0].ep);
                    check("s_last",  s_last,  exp_q[0].last);
                end
            end
            if (w_load)  wl_pulses++;
            if (hdr_err) he_pulses++;
            if (done) begin
                fin = 1;
                break;
            end
            if (sent < FLEN) begin
                in_valid = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_data  = frame_q[sent];
            end else if (junk) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                check("junk_in_ready", in_ready, 0);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            if (rmode == 0)      s_ready = 1'b1;
            else if (rmode == 1) begin
                s_ready = tgl;
                if (s_valid) tgl = ~tgl;
            end else             s_ready = 1'($urandom_range(0, 1));
            took      = in_valid && in_ready;
            xfer      = s_valid && s_ready && (exp_q.size() > 0);
            xfer_last = xfer && exp_q[0].last;
            if (xfer) void'(exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                sent++;
                if (sent == 2 + D) begin
                    check("w_load", w_load, 1);
                    check("w_init", w_init, w_exp);
                end
                if (sent == FLEN) begin
                    check("first_valid", s_valid, (e != 0));
                    if (e == 0) check("done_e0", done, 1);
                end
            end
            if (xfer_last) begin
                check("done_after_last",  done,    1);
                check("valid_after_last", s_valid, 0);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        s_ready  = 1'b0;
        check("frame_timeout",  fin,          1);
        check("w_load_pulses",  wl_pulses,    1);
        check("hdr_err_pulses", he_pulses,    0);
        check("exp_drained",    exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done,     0);
        check("hunt_busy",      busy,     0);
        check("hunt_in_ready",  in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Reference frame, E=1, ready always high
        frame_q = '{8'hA5, 8'h01, 8'h04, 8'h09, 8'h02, 8'h03, 8'h00,
                    8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
        run_frame(0, 0);

        // Same frame, E=2, s_ready toggling
        frame_q[1] = 8'h02;
        run_frame(1, 0);

        // Junk leading byte, then a valid frame
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(posedge clk); #1;
        check("hdr_err_pulse", hdr_err, 1);
        check("hdr_err_hunt",  busy,    0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("hdr_err_once",  hdr_err, 0);
        run_frame(2, 0);

        // Zero epochs
        frame_q[1] = 8'h00;
        run_frame(0, 0);

        // Reset after 7 bytes, then a full frame
        random_frame(8'd2);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = frame_q[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        check_reset_values();
        run_frame(0, 0);

        // Junk on in_valid during streaming, then a clean frame from HUNT
        random_frame(8'd2);
        run_frame(2, 1);
        random_frame(8'd1);
        run_frame(0, 0);

        // Random frames, first one with a header byte inside the weights
        for (int r = 0; r < 6; r++) begin
            random_frame(8'($urandom_range(1, 4)));
            if (r == 0) frame_q[2] = HDR_BYTE_DEF;
            if (r == 1) frame_q[5] = HDR_BYTE_DEF;
            run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Maximum epoch count
        random_frame(8'd255);
        run_frame(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
